// File: rtl/sel_pipe_pkg.sv
// Shared definitions for the selector pipeline stage: buffer states and the
// effective-index rule applied to an incoming Control value.
package sel_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] index;
    logic        out_range;
  } sel_info_t;

  // Out-of-range Control values fall back to the default source and are flagged.
  function automatic sel_info_t sel_eval(input logic [31:0] control,
                                         input int unsigned num_inputs,
                                         input int unsigned default_input);
    sel_info_t info;
    info.out_range = (control >= num_inputs);
    info.index     = info.out_range ? default_input : control;
    return info;
  endfunction

endpackage

// File: rtl/sel_nway.sv
// Combinational WIDTH x NUM_INPUTS selector with a fallback source for
// out-of-range indices; also reports the index actually used.
module sel_nway
  import sel_pipe_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int NUM_INPUTS    = 4,
  parameter int DEFAULT_INPUT = 0
) (
  input  logic [NUM_INPUTS*WIDTH-1:0]     inputs,
  input  logic [$clog2(NUM_INPUTS)-1:0]   control,
  output logic [WIDTH-1:0]                data,
  output logic [$clog2(NUM_INPUTS)-1:0]   index,
  output logic                            out_range
);

  localparam int SEL_W = $clog2(NUM_INPUTS);

  logic [WIDTH-1:0] src [NUM_INPUTS];
  sel_info_t        info;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_src
    assign src[gi] = inputs[gi*WIDTH +: WIDTH];
  end

  assign info      = sel_eval(32'(control), NUM_INPUTS, DEFAULT_INPUT);
  assign out_range = info.out_range;

  always_comb begin
    data  = '0;
    index = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (info.index == i) begin
        data  = src[i];
        index = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/sel_pipe_reg.sv
// N-way selector feeding a two-entry skid buffer with valid/ready on both
// sides; every output, including InReady, comes straight from a flop.
module sel_pipe_reg
  import sel_pipe_pkg::*;
#(
  parameter int                 WIDTH         = 32,
  parameter int                 NUM_INPUTS    = 4,
  parameter int                 SEL_W         = $clog2(NUM_INPUTS),
  parameter logic [WIDTH-1:0]   RESET_VALUE   = {WIDTH{1'b0}},
  parameter int                 DEFAULT_INPUT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_INPUTS*WIDTH-1:0]   Inputs,
  input  logic [SEL_W-1:0]              Control,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic                          Flush,
  output logic [WIDTH-1:0]              Output,
  output logic [SEL_W-1:0]              OutSel,
  output logic                          OutRange,
  output logic                          OutValid,
  input  logic                          OutReady
);

  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] sel_index;
  logic             sel_range;

  sel_nway #(
    .WIDTH        (WIDTH),
    .NUM_INPUTS   (NUM_INPUTS),
    .DEFAULT_INPUT(DEFAULT_INPUT)
  ) u_sel (
    .inputs   (Inputs),
    .control  (Control),
    .data     (sel_data),
    .index    (sel_index),
    .out_range(sel_range)
  );

  state_t           state_reg, state_next;
  logic             out_valid_reg, in_ready_reg;
  logic [WIDTH-1:0] main_data_reg, skid_data_reg;
  logic [SEL_W-1:0] main_sel_reg, skid_sel_reg;
  logic             main_range_reg, skid_range_reg;

  logic accept, pop;
  logic load_main_in, load_main_skid, load_skid;

  assign accept = InValid && in_ready_reg;
  assign pop    = out_valid_reg && OutReady;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next   = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_next     = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Flush shares the reset path so a word offered in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      state_reg      <= ST_EMPTY;
      out_valid_reg  <= 1'b0;
      in_ready_reg   <= 1'b1;
      main_data_reg  <= RESET_VALUE;
      main_sel_reg   <= '0;
      main_range_reg <= 1'b0;
      skid_data_reg  <= RESET_VALUE;
      skid_sel_reg   <= '0;
      skid_range_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next != ST_EMPTY);
      in_ready_reg  <= (state_next != ST_TWO);
      if (load_main_in) begin
        main_data_reg  <= sel_data;
        main_sel_reg   <= sel_index;
        main_range_reg <= sel_range;
      end else if (load_main_skid) begin
        main_data_reg  <= skid_data_reg;
        main_sel_reg   <= skid_sel_reg;
        main_range_reg <= skid_range_reg;
      end
      if (load_skid) begin
        skid_data_reg  <= sel_data;
        skid_sel_reg   <= sel_index;
        skid_range_reg <= sel_range;
      end
    end
  end

  assign Output   = main_data_reg;
  assign OutSel   = main_sel_reg;
  assign OutRange = main_range_reg;
  assign OutValid = out_valid_reg;
  assign InReady  = in_ready_reg;

endmodule
